// File: rtl/sec32_encoder.sv
// Streaming SEC check-bit generator: 32-bit data in, data plus 8 check bits out, 2-entry skid pipeline.
// Optional error injection is enabled by defining SEC32_ERR_INJECT_EN.
module sec32_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  output logic [CNT_W-1:0] word_count
`ifdef SEC32_ERR_INJECT_EN
  ,
  input  logic             inj_arm,
  input  logic [5:0]       inj_pos,
  output logic             inj_done
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Each check bit is even parity over a fixed subset of the data bits.
  function automatic logic [7:0] sec_check(input logic [31:0] d);
    logic [7:0] c;
    c[0] = ^(d & 32'h00FF1111);
    c[1] = ^(d & 32'hFF002222);
    c[2] = ^(d & 32'h0F0F4444);
    c[3] = ^(d & 32'hF0F08888);
    c[4] = ^(d & 32'h111100FF);
    c[5] = ^(d & 32'h2222FF00);
    c[6] = ^(d & 32'h44440F0F);
    c[7] = ^(d & 32'h8888F0F0);
    return c;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        m_data_r;
  logic [7:0]         m_check_r;
  logic [31:0]        s_data_r;
  logic [7:0]         s_check_r;
  logic [CNT_W-1:0]   count_r;
  logic               accept_s;
  logic               transfer_s;
  logic               load_m_in_s;
  logic               load_m_skid_s;
  logic               load_s_s;
  logic [39:0]        flip_s;
  logic [39:0]        code_s;

  assign accept_s   = in_valid & in_ready_r;
  assign transfer_s = out_valid_r & out_ready;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = m_data_r;
  assign out_check  = m_check_r;
  assign word_count = count_r;

  // Encoded codeword for the word on the input, with any injected flip applied.
  always_comb begin
    code_s = {sec_check(in_data), in_data} ^ flip_s;
  end

  // Occupancy next-state and register load selects.
  always_comb begin
    state_next_s  = state_r;
    load_m_in_s   = 1'b0;
    load_m_skid_s = 1'b0;
    load_s_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_next_s = ONE;
          load_m_in_s  = 1'b1;
        end else begin
          state_next_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && transfer_s) begin
          load_m_in_s  = 1'b1;
        end else if (accept_s) begin
          state_next_s = TWO;
          load_s_s     = 1'b1;
        end else if (transfer_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = ONE;
        end
      end
      TWO: begin
        if (transfer_s) begin
          state_next_s  = ONE;
          load_m_skid_s = 1'b1;
        end else begin
          state_next_s  = TWO;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // State, handshake flags, storage and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      m_data_r    <= 32'd0;
      m_check_r   <= 8'd0;
      s_data_r    <= 32'd0;
      s_check_r   <= 8'd0;
      count_r     <= '0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s != TWO);
      out_valid_r <= (state_next_s != EMPTY);
      if (load_m_in_s) begin
        m_data_r  <= code_s[31:0];
        m_check_r <= code_s[39:32];
      end else if (load_m_skid_s) begin
        m_data_r  <= s_data_r;
        m_check_r <= s_check_r;
      end
      if (load_s_s) begin
        s_data_r  <= code_s[31:0];
        s_check_r <= code_s[39:32];
      end
      if (transfer_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef SEC32_ERR_INJECT_EN
  logic       armed_r;
  logic [5:0] pos_r;
  logic       done_r;

  assign inj_done = done_r;

  // Flip the latched codeword position of the next accepted word while armed.
  always_comb begin
    flip_s = 40'd0;
    if (armed_r && (pos_r < 6'd40)) begin
      flip_s = 40'd1 << pos_r;
    end else begin
      flip_s = 40'd0;
    end
  end

  // A new arm request overrides the consumption of the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r <= 1'b0;
      pos_r   <= 6'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= armed_r & accept_s;
      if (inj_arm) begin
        armed_r <= 1'b1;
        pos_r   <= inj_pos;
      end else if (accept_s) begin
        armed_r <= 1'b0;
      end
    end
  end
`else
  assign flip_s = 40'd0;
`endif

endmodule

// File: tb/tb_sec32_encoder.sv
// Directed self-checking bench for sec32_encoder; a second instance with CNT_W=4 checks counter wrap.
module tb_sec32_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic [15:0] word_count;
  logic        in_ready_w;
  logic        out_valid_w;
  logic [31:0] out_data_w;
  logic [7:0]  out_check_w;
  logic [3:0]  word_count_w;
`ifdef SEC32_ERR_INJECT_EN
  logic        inj_arm;
  logic [5:0]  inj_pos;
  logic        inj_done;
  logic        inj_done_w;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] vec_data  [5] = '{32'h00000001, 32'h00010000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
  logic [7:0]  vec_check [5] = '{8'h51, 8'h15, 8'h8A, 8'h00, 8'h00};

  sec32_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_check(out_check),
    .word_count(word_count)
`ifdef SEC32_ERR_INJECT_EN
    , .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_done(inj_done)
`endif
  );

  sec32_encoder #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .out_check(out_check_w),
    .word_count(word_count_w)
`ifdef SEC32_ERR_INJECT_EN
    , .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_done(inj_done_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
`ifdef SEC32_ERR_INJECT_EN
    inj_arm   = 1'b0;
    inj_pos   = 6'd0;
`endif
    do_reset();

    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_count", {48'd0, word_count}, 64'd0);
    chk("reset_data", {32'd0, out_data}, 64'd0);
    chk("reset_check", {56'd0, out_check}, 64'd0);

    // Encoding vectors, streamed with out_ready held high
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = vec_data[i];
      tick();
      chk("enc_valid", {63'd0, out_valid}, 64'd1);
      chk("enc_data", {32'd0, out_data}, {32'd0, vec_data[i]});
      chk("enc_check", {56'd0, out_check}, {56'd0, vec_check[i]});
    end
    in_valid = 1'b0;
    tick();
    chk("enc_drained", {63'd0, out_valid}, 64'd0);
    chk("enc_count", {48'd0, word_count}, 64'd5);

    // Backpressure: A and B fill the pipe, C is held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA0001;
    tick();
    chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_a_data", {32'd0, out_data}, 64'hAAAA0001);
    in_data = 32'hBBBB0002;
    tick();
    chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_b_head", {32'd0, out_data}, 64'hAAAA0001);
    in_data = 32'hCCCC0003;
    tick();
    chk("bp_c_held", {63'd0, in_ready}, 64'd0);
    chk("bp_stable_data", {32'd0, out_data}, 64'hAAAA0001);
    tick();
    chk("bp_stable_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_stable_data2", {32'd0, out_data}, 64'hAAAA0001);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", {32'd0, out_data}, 64'hBBBB0002);
    chk("bp_ready_again", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_out_c", {32'd0, out_data}, 64'hCCCC0003);
    chk("bp_out_c_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", {63'd0, out_valid}, 64'd0);
    chk("bp_count", {48'd0, word_count}, 64'd8);
    chk("bp_count_w", {60'd0, word_count_w}, 64'd8);

    // 100 back-to-back words with simultaneous accept and transfer
    do_reset();
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h10000000 + i * 32'h01010101;
      tick();
      chk("stream_data", {32'd0, out_data}, {32'd0, 32'h10000000 + i * 32'h01010101});
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_count", {48'd0, word_count}, 64'd100);
    chk("stream_count_w", {60'd0, word_count_w}, 64'd4);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h00000100 + i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_count_w", {60'd0, word_count_w}, 64'd1);
    chk("wrap_count", {48'd0, word_count}, 64'd17);

    // Reset while the pipe holds two words
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0DEAD001;
    tick();
    in_data   = 32'h0DEAD002;
    tick();
    chk("two_in_ready", {63'd0, in_ready}, 64'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_count", {48'd0, word_count}, 64'd0);
    chk("mid_rst_data", {32'd0, out_data}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_word", {63'd0, out_valid}, 64'd0);
    end
    chk("no_stale_count", {48'd0, word_count}, 64'd0);

`ifdef SEC32_ERR_INJECT_EN
    // Injection on check bit 1, then an out-of-range position
    inj_arm = 1'b1;
    inj_pos = 6'd33;
    tick();
    inj_arm  = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    tick();
    in_valid = 1'b0;
    chk("inj_check", {56'd0, out_check}, 64'h53);
    chk("inj_data", {32'd0, out_data}, 64'h1);
    chk("inj_done", {63'd0, inj_done}, 64'd1);
    tick();
    chk("inj_done_pulse", {63'd0, inj_done}, 64'd0);
    inj_arm = 1'b1;
    inj_pos = 6'd45;
    tick();
    inj_arm  = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    tick();
    chk("inj45_check", {56'd0, out_check}, 64'h51);
    chk("inj45_data", {32'd0, out_data}, 64'h1);
    chk("inj45_done", {63'd0, inj_done}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("inj_disarmed_check", {56'd0, out_check}, 64'h51);
    chk("inj_disarmed_done", {63'd0, inj_done}, 64'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sec32_encoder.md
Name: sec32_encoder

Overview:
- Streaming single-error-correcting (SEC) check-bit generator for 32-bit words; it is the transmit side of the team's c1355-style 32-bit SEC corrector.
- Accepts data words over a valid/ready interface and appends 8 check bits, so that a downstream corrector with its check-enable asserted computes an all-zero syndrome.
- Fully registered 2-entry skid pipeline; sits on the write path ahead of the protected storage or link.

Parameters:
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  encoder can accept a word.
- in_data  input  32  data word; d[k] = in_data[k].
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  32  data, passed through.
- out_check  output  8  check bits c[7:0].
- word_count  output  CNT_W  count of completed output handshakes.

Behaviour:
- Check equations (XOR, even parity), computed on the input side and registered alongside the data:
  - c0 = d0^d4^d8^d12^d16^d17^d18^d19^d20^d21^d22^d23
  - c1 = d1^d5^d9^d13^d24^…^d31
  - c2 = d2^d6^d10^d14^d16^d17^d18^d19^d24^d25^d26^d27
  - c3 = d3^d7^d11^d15^d20^d21^d22^d23^d28^d29^d30^d31
  - c4 = d16^d20^d24^d28^d0^…^d7
  - c5 = d17^d21^d25^d29^d8^…^d15
  - c6 = d18^d22^d26^d30^d0^d1^d2^d3^d8^d9^d10^d11
  - c7 = d19^d23^d27^d31^d4^d5^d6^d7^d12^d13^d14^d15
- Handshakes: input accept = in_valid & in_ready; output transfer = out_valid & out_ready.
- Storage: main register M (drives the outputs) and skid register S.
- Occupancy FSM:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: M holds a word; out_valid=1, in_ready=1.
  - TWO: M and S hold words; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: accept -> ONE, word loaded into M.
  - ONE: accept without transfer -> TWO (word into S); transfer without accept -> EMPTY; accept and transfer together -> stays ONE, new word loaded into M.
  - TWO: transfer -> ONE, S moved into M. No accept is possible in TWO.
- Latency: a word accepted in cycle N shows on out_valid in cycle N+1 when the pipe is empty.
- Ordering: strictly FIFO. No word is ever dropped or duplicated.
- in_ready is a registered function of the state; it has no combinational path from out_ready.
- Output stability: out_data and out_check hold stable while out_valid=1 and out_ready=0.
- word_count: increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset:
  - In any state, rst=1 forces EMPTY, out_valid=0, in_ready=1, word_count=0, out_data=0, out_check=0.
  - Words in flight are discarded.
  - in_ready is 1 in the cycle after reset.

Optional Feature:
- Macro SEC32_ERR_INJECT_EN.
- When defined, adds ports inj_arm (input, 1), inj_pos (input, 6) and inj_done (output, 1, pulse).
- Arming: inj_arm=1 sets an armed flag and latches inj_pos.
- Injection: the next accepted word has codeword bit inj_pos flipped before it is registered.
  - Positions 0–31 map to out_data[pos]; positions 32–39 map to out_check[pos-32].
  - The armed flag then clears and inj_done pulses for 1 cycle.
- inj_pos ≥ 40 disarms without flipping; inj_done still pulses.
- Arming while already armed replaces the latched position.
- Reset clears the armed flag.
- When undefined: no extra ports, and the output codeword is always clean.

Test Plan:
- Encoding values (out_ready=1):
  - in_data=0x00000001 -> out_check=0x51.
  - 0x00010000 -> 0x15.
  - 0x80000000 -> 0x8A.
  - 0xFFFFFFFF -> 0x00.
  - 0x00000000 -> 0x00.
  - Each word appears one cycle after acceptance.
- Backpressure: hold out_ready=0 and push 3 words A, B, C -> A and B are accepted, in_ready=0 after B, C is held. Raise out_ready -> A, B, C come out in order with no gaps once flowing, and word_count=3.
- Simultaneous accept and transfer in ONE, for 100 back-to-back cycles -> one word per cycle, in_ready stays 1, word_count=100.
- Reset mid-stream in state TWO -> next cycle out_valid=0, in_ready=1, word_count=0, and no stale word appears afterwards.
- Counter wrap (CNT_W=4): 17 transfers -> word_count=1.
- With SEC32_ERR_INJECT_EN:
  - inj_pos=33 on data 0x00000001 -> out_check=0x53 and inj_done pulses.
  - inj_pos=45 -> clean codeword and inj_done pulses.
